pipelined_shifter: RTL
======================

// Module: pipelined_shifter
// PURPOSE
//  Parametrised, pipelined logarithmic shifter for the ALU shift path: SLL, SRL, SRA, ROR by 0..WIDTH-1.
//  One mux level per shift-amount bit, one register after each level.
//  A valid/ready handshake at both ends lets the execute stage stall it without dropping operations.
//  Carries a writeback tag alongside each operation.
// PARAMETERS
//  WIDTH    32                 data width; power of two, >= 4
//  SHAMT_W  $clog2(WIDTH)      shift-amount width = number of pipeline levels
//  TAG_W    5                  tag width (destination register index)
// PORTS
//  clock      in   1        rising-edge clock
//  reset      in   1        synchronous, active-high reset
//  in_valid   in   1        operation presented
//  in_ready   out  1        pipeline accepts this cycle
//  in_data    in   WIDTH    operand A
//  in_shamt   in   SHAMT_W  shift amount
//  in_op      in   2        00 SLL, 01 SRL, 10 SRA, 11 ROR
//  in_tag     in   TAG_W    carried unchanged to output
//  out_valid  out  1        result available
//  out_ready  in   1        consumer takes result
//  out_data   out  WIDTH    shifted result
//  out_tag    out  TAG_W    tag of this result
//  out_zero   out  1        out_data == 0
// BEHAVIOUR
//  - Reset (sync, active-high): all stage valid bits cleared, so in_ready=1 on the cycle after reset.
//    Reset data, tag and shamt registers to 0, so out_data=0, out_tag=0, out_zero=1, out_valid=0.
//    A reset asserted mid-operation discards every in-flight op; nothing is output afterwards.
//  - Level k (k = SHAMT_W-1 down to 0, MSB first) shifts by 2^k when shamt bit k is set, else passes data.
//    The level output is registered into stage k together with op, remaining shamt bits, sign and tag.
//  - Fill per level:
//    - SLL: zeros enter at the LSB end.
//    - SRL: zeros enter at the MSB end.
//    - SRA: copies of the ORIGINAL operand's bit WIDTH-1 enter at the MSB end.
//      That sign bit is captured at input and piped; it is never taken from intermediate data.
//    - ROR: bits shifted out at the LSB end re-enter at the MSB end.
//  - Latency: SHAMT_W cycles from accept (in_valid & in_ready) to out_valid, with no stalls.
//    Throughput: 1 op/cycle.
//  - Handshake: stage s advances when it is empty or stage s+1 advances; the last stage advances on out_ready.
//    in_ready = first stage advances.
//    in_ready is combinational from out_ready through the stall chain (no skid buffer).
//    With the pipeline full and out_ready=0, all stages hold and in_ready=0.
//    out_data, out_tag and out_zero stay stable while out_valid=1 and out_ready=0.
//  - Simultaneous accept and emit while full with out_ready=1: everything shifts one stage, nothing is lost.
//  - Results leave in acceptance order; every op takes the same path.
//  - shamt=0 on any op: out_data = in_data.
// CONFIGURATION
//  - Macro PIPELINED_SHIFTER_ROTATE_EN:
//    - Defined: op 11 performs ROR as above.
//    - Undefined: no rotate wiring is built; op 11 behaves exactly as SRL.
// STRUCTURE
//  - Package shifter_pkg:
//    - shift_op_e enum: OP_SLL=2'b00, OP_SRL=2'b01, OP_SRA=2'b10, OP_ROR=2'b11.
//    - Stage payload struct: data, op, sign, shamt, tag.
//  - Sub-module shift_level: one combinational 2^k shift with mode fill, plus payload register and valid/stall logic.
//    Parameterised by WIDTH and level index K.
//    pipelined_shifter instantiates SHAMT_W of them in a generate loop.
// TESTING
//  1. SRA 0x8000_0000 by 31 -> 0xFFFF_FFFF after 5 cycles.
//     SRA 0x7FFF_FFF0 by 4 -> 0x07FF_FFFF.
//  2. SLL 0x0000_0001 by 31 -> 0x8000_0000; SRL 0x8000_0000 by 31 -> 0x0000_0001.
//     Both with shamt 0 -> unchanged input.
//  3. ROR 0x0000_00F1 by 4 -> 0x1000_000F with the macro defined, 0x0000_000F with it undefined.
//  4. Back-to-back stream of 8 ops with tags 0..7 and out_ready=1 -> 8 consecutive results, in tag order.
//     Then out_ready=0 for 6 cycles -> 5 held, in_ready=0, output stable.
//     Then release -> results resume in order, none dropped.
//  5. Reset during the stream with 3 ops in flight -> out_valid=0 on the next cycle and in_ready=1.
//     No stale result ever appears.
//  6. SLL 0x0000_0001 by 31, then SRL 0x0000_0001 by 1 -> out_zero=0, then out_zero=1.
//     Repeat 1-2 with WIDTH=16, SHAMT_W=4 -> latency 4.

Source files
------------

// File: rtl/pipelined_shifter_pkg.sv
// Shared types for the pipelined logarithmic shifter.
// Rotate support is controlled by PIPELINED_SHIFTER_ROTATE_EN (see shift_level).
package shifter_pkg;

    localparam int OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROR = 2'b11
    } shift_op_e;

endpackage

// File: rtl/pipelined_shifter_if.sv
// Request/response handshake bundle for the pipelined shifter.
// The shifter uses the slave modport; the producer/consumer side uses master.
interface pipelined_shifter_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH),
    parameter int TAG_W   = 5
);
    import shifter_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic [SHAMT_W-1:0] in_shamt;
    shift_op_e          in_op;
    logic [TAG_W-1:0]   in_tag;

    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic [TAG_W-1:0]   out_tag;
    logic               out_zero;

    modport master (
        output in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag, out_zero
    );

    modport slave (
        input  in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag, out_zero
    );

endinterface

// File: rtl/pipelined_shifter_level.sv
// One shifter level: conditional shift by 2^K with op-dependent fill, then a payload register.
// Rotate wiring exists only when PIPELINED_SHIFTER_ROTATE_EN is defined; otherwise ROR falls to SRL.
module shift_level
    import shifter_pkg::*;
#(
    parameter int  WIDTH = 32,
    parameter int  K     = 0,
    parameter type pld_t = logic
) (
    input  logic clock,
    input  logic reset,
    input  logic adv_i,
    input  logic up_valid_i,
    input  pld_t up_pld_i,
    output logic valid_o,
    output pld_t pld_o
);
    localparam int S = 1 << K;

    logic [WIDTH-1:0] src;
    logic [WIDTH-1:0] shifted;
    pld_t             pld_d;
    pld_t             pld_q;
    logic             valid_q;

    assign src = up_pld_i.data;

    // SRA fill uses the sign captured at the pipe input, not the partially shifted data.
    always_comb begin
        shifted = src;
        if (up_pld_i.shamt[K]) begin
            case (up_pld_i.op)
                OP_SLL:  shifted = src << S;
                OP_SRA:  shifted = {{S{up_pld_i.sign}}, src[WIDTH-1:S]};
`ifdef PIPELINED_SHIFTER_ROTATE_EN
                OP_ROR:  shifted = {src[S-1:0], src[WIDTH-1:S]};
`endif
                default: shifted = src >> S;
            endcase
        end
    end

    always_comb begin
        pld_d      = up_pld_i;
        pld_d.data = shifted;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= 1'b0;
            pld_q   <= '0;
        end else if (adv_i) begin
            valid_q <= up_valid_i;
            if (up_valid_i) begin
                pld_q <= pld_d;
            end
        end
    end

    assign valid_o = valid_q;
    assign pld_o   = pld_q;

endmodule

// File: rtl/pipelined_shifter.sv
// Pipelined logarithmic shifter (SLL/SRL/SRA/ROR), one registered level per shamt bit, MSB level first.
// Optional rotate: define PIPELINED_SHIFTER_ROTATE_EN; otherwise op 11 behaves as SRL.
module pipelined_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH),
    parameter int TAG_W   = 5
) (
    input logic                clock,
    input logic                reset,
    pipelined_shifter_if.slave bus
);
    // Payload widths depend on instance parameters, so the struct lives here and is passed down as a type.
    typedef struct packed {
        logic [WIDTH-1:0]   data;
        shift_op_e          op;
        logic               sign;
        logic [SHAMT_W-1:0] shamt;
        logic [TAG_W-1:0]   tag;
    } payload_t;

    payload_t           pld [SHAMT_W:0];
    logic [SHAMT_W:0]   vld_pipe;
    logic [SHAMT_W-1:0] adv;
    logic               unused_tail;

    // Index SHAMT_W is the input side; stage 0 drives the output.
    assign vld_pipe[SHAMT_W] = bus.in_valid;
    assign pld[SHAMT_W]      = '{data:  bus.in_data,
                                 op:    bus.in_op,
                                 sign:  bus.in_data[WIDTH-1],
                                 shamt: bus.in_shamt,
                                 tag:   bus.in_tag};

    genvar k;
    generate
        for (k = 0; k < SHAMT_W; k++) begin : g_lvl
            // Stage k moves if it or any stage between it and the output has a bubble, or the consumer takes.
            assign adv[k] = bus.out_ready || !(&vld_pipe[k:0]);

            shift_level #(
                .WIDTH (WIDTH),
                .K     (k),
                .pld_t (payload_t)
            ) u_lvl (
                .clock      (clock),
                .reset      (reset),
                .adv_i      (adv[k]),
                .up_valid_i (vld_pipe[k+1]),
                .up_pld_i   (pld[k+1]),
                .valid_o    (vld_pipe[k]),
                .pld_o      (pld[k])
            );
        end
    endgenerate

    assign bus.in_ready  = adv[SHAMT_W-1];
    assign bus.out_valid = vld_pipe[0];
    assign bus.out_data  = pld[0].data;
    assign bus.out_tag   = pld[0].tag;
    assign bus.out_zero  = (pld[0].data == '0);

    assign unused_tail = ^{pld[0].op, pld[0].sign, pld[0].shamt};

endmodule
